fb_reader: RTL and testbench

Framebuffer read stage sitting directly upstream of the `vga` timing generator. It fetches pixels from framebuffer memory through a single-outstanding request/acknowledge read port, buffers them in an internal first-word-fall-through (FWFT) FIFO, and presents them to the display stage over a valid/ready stream tagged with start-of-frame and end-of-line markers. It runs entirely in the pixel clock domain.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/fb_reader_if.sv | 36 +++
 rtl/fb_reader_sync_fifo.sv | 61 ++++++
 rtl/fb_reader.sv | 151 +++++++++++++++
 tb/tb_fb_reader.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types for the framebuffer read path feeding the vga timing stage.
//   HDISP_DEFAULT / VDISP_DEFAULT : default active resolution
//   rgb_t      : 24-bit RGB 8:8:8 pixel
//   pix_word_t : one FIFO entry, pixel plus its start-of-frame / end-of-line tags
//   fb_state_t : fetch FSM states
package vga_pkg;

  localparam int HDISP_DEFAULT = 800;
  localparam int VDISP_DEFAULT = 480;

  typedef logic [23:0] rgb_t;

  typedef struct packed {
    rgb_t rgb;
    logic sof;
    logic eol;
  } pix_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    READ  = 2'd2,
    FLUSH = 2'd3
  } fb_state_t;

endpackage

// File: rtl/fb_reader_if.sv
// Bus bundle of fb_reader: memory read port plus outgoing pixel stream.
//   rd_req/rd_addr/rd_ack/rd_data : single-outstanding memory read
//   pix_valid/pix_ready/pix_data/pix_sof/pix_eol : pixel stream to display
//
// Handshakes: a memory read completes in the cycle where rd_req & rd_ack are
// both high; rd_addr is held while rd_req=1 and rd_ack=0. A pixel transfers in
// the cycle where pix_valid & pix_ready are both high; while pix_valid=1 and
// pix_ready=0 the pixel fields are held stable. pix_valid never waits on
// pix_ready.
interface fb_reader_if;
  import vga_pkg::*;

  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;

  logic        pix_valid;
  logic        pix_ready;
  rgb_t        pix_data;
  logic        pix_sof;
  logic        pix_eol;

  // master: the framebuffer reader
  modport master (
    output rd_req, rd_addr, pix_valid, pix_data, pix_sof, pix_eol,
    input  rd_ack, rd_data, pix_ready
  );

  // slave: memory plus display consumer
  modport slave (
    input  rd_req, rd_addr, pix_valid, pix_data, pix_sof, pix_eol,
    output rd_ack, rd_data, pix_ready
  );

endinterface

// File: rtl/fb_reader_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst       : clock, synchronous active-high reset
//   clr            : synchronous clear (drops all entries)
//   push, wdata    : write; ignored when full unless a pop happens this cycle
//   pop            : consume head; ignored when empty
//   rdata, valid   : head entry, visible as soon as it is written
//   count          : entries held (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_reader.sv
// fb_reader: fetches framebuffer words in bursts and streams them as pixels.
//   pixel_clk, pixel_rst : clock, synchronous active-high reset
//   enable               : fetch enable; dropping it flushes and restarts at (0,0)
//   base_addr            : byte address of pixel (0,0), taken at frame start
//   bus                  : memory read port and pixel stream (fb_reader_if)
//   state_dbg            : current fetch FSM state
module fb_reader
  import vga_pkg::*;
#(
  parameter int HDISP      = HDISP_DEFAULT,
  parameter int VDISP      = VDISP_DEFAULT,
  parameter int FIFO_DEPTH = 256,
  parameter int BURST      = 16
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        enable,
  input  logic [31:0] base_addr,
  fb_reader_if.master bus,
  output fb_state_t   state_dbg
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fb_state_t              state;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [BW-1:0]          burst_cnt;
  logic                   drop;
  logic                   rd_req_q;
  logic [31:0]            rd_addr_q;

  logic                   x_last;
  logic                   y_last;
  logic                   space_ok;
  logic                   push;
  logic                   clr;
  pix_word_t              wr_word;
  pix_word_t              rd_word;
  logic [$bits(pix_word_t)-1:0] fifo_rdata;
  logic                   fifo_valid;
  logic [CW-1:0]          fifo_count;
  logic                   unused_rd_bits;

  assign x_last   = (x == XW'(HDISP - 1));
  assign y_last   = (y == YW'(VDISP - 1));
  assign space_ok = (CW'(FIFO_DEPTH) - fifo_count) >= CW'(BURST);
  // Once enable has dropped during READ the outstanding word is only waited
  // for, never stored.
  assign push     = (state == READ) && bus.rd_ack && enable && !drop;
  assign clr      = (state == FLUSH);
  assign wr_word  = '{rgb: bus.rd_data[23:0],
                      sof: (x == '0) && (y == '0),
                      eol: x_last};
  assign unused_rd_bits = &{1'b0, bus.rd_data[31:24]};

  sync_fifo #(
    .WIDTH ($bits(pix_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pixel_clk),
    .rst   (pixel_rst),
    .clr   (clr),
    .push  (push),
    .wdata (wr_word),
    .pop   (bus.pix_ready),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  // Entry storage is not reset, so the visible fields are masked when empty.
  assign rd_word       = pix_word_t'(fifo_rdata);
  assign bus.pix_valid = fifo_valid;
  assign bus.pix_data  = fifo_valid ? rd_word.rgb : '0;
  assign bus.pix_sof   = fifo_valid && rd_word.sof;
  assign bus.pix_eol   = fifo_valid && rd_word.eol;
  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = rd_addr_q;
  assign state_dbg     = state;

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state     <= IDLE;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      x         <= '0;
      y         <= '0;
      burst_cnt <= '0;
      drop      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            // x/y are already at (0,0) here, so this is a frame start.
            state     <= CHECK;
            rd_addr_q <= base_addr;
          end
        end

        CHECK: begin
          if (!enable) begin
            state <= FLUSH;
          end else if (space_ok) begin
            state     <= READ;
            rd_req_q  <= 1'b1;
            burst_cnt <= '0;
            drop      <= 1'b0;
          end
        end

        READ: begin
          if (!enable) drop <= 1'b1;
          if (bus.rd_ack) begin
            if (!enable || drop) begin
              rd_req_q <= 1'b0;
              state    <= FLUSH;
            end else begin
              if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + YW'(1);
              end else begin
                x <= x + XW'(1);
              end
              rd_addr_q <= (x_last && y_last) ? base_addr : rd_addr_q + 32'd4;
              burst_cnt <= burst_cnt + BW'(1);
              if (burst_cnt == BW'(BURST - 1)) begin
                rd_req_q <= 1'b0;
                state    <= CHECK;
              end
            end
          end
        end

        FLUSH: begin
          x         <= '0;
          y         <= '0;
          rd_addr_q <= base_addr;
          drop      <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_reader.sv
// Bench for fb_reader with an 8x4 frame, 4-word bursts and a 16-entry FIFO.
// A memory model answers reads with data = address; expected pixels are
// queued by the stimulus and checked by an independent output monitor.
module tb_fb_reader;
  import vga_pkg::*;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int B     = 4;
  localparam int D     = 16;
  localparam int FRAME = H * V;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic        enable    = 1'b0;
  logic [31:0] base_addr = '0;
  fb_state_t   state_dbg;

  fb_reader_if bus ();

  fb_reader #(
    .HDISP      (H),
    .VDISP      (V),
    .FIFO_DEPTH (D),
    .BURST      (B)
  ) dut (
    .pixel_clk (pixel_clk),
    .pixel_rst (pixel_rst),
    .enable    (enable),
    .base_addr (base_addr),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 pixel_clk = ~pixel_clk;

  // ---------------- counters / knobs ----------------
  int          n_cmp      = 0;
  int          n_err      = 0;
  int          ack_cnt    = 0;
  logic        ready_en   = 1'b0;
  logic        rand_ready = 1'b0;
  logic        mem_mode   = 1'b0;   // 0: fixed mem_delay, 1: random 0..5
  int          mem_delay  = 0;
  logic        stray_ack  = 1'b0;
  logic [25:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] exp_pix(input logic [31:0] base, input int k);
    logic [31:0] a;
    a = base + 32'(4 * k);
    return {a[23:0], (k == 0), ((k % H) == H - 1)};
  endfunction

  task automatic push_seq(input logic [31:0] base, input int start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_pix(base, (start + i) % FRAME));
  endtask

  // ---------------- memory model ----------------
  int          wait_cnt  = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic int pick_delay();
    return mem_mode ? int'($urandom_range(0, 5)) : mem_delay;
  endfunction

  always @(negedge pixel_clk) begin
    bus.rd_ack = 1'b0;
    if (stray_ack) begin
      bus.rd_ack  = 1'b1;
      bus.rd_data = 32'h00AB_CDEF;
      prev_wait   = 1'b0;
    end else if (bus.rd_req) begin
      if (prev_wait) check("rd_addr_stable", bus.rd_addr, prev_addr);
      if (wait_cnt == 0) begin
        bus.rd_ack  = 1'b1;
        bus.rd_data = bus.rd_addr;
        ack_cnt++;
        wait_cnt  = pick_delay();
        prev_wait = 1'b0;
      end else begin
        wait_cnt--;
        prev_wait = 1'b1;
        prev_addr = bus.rd_addr;
      end
    end else begin
      wait_cnt  = pick_delay();
      prev_wait = 1'b0;
    end
  end

  // ---------------- consumer ready ----------------
  always @(negedge pixel_clk) begin
    bus.pix_ready = ready_en && (exp_q.size() != 0) &&
                    (!rand_ready || ($urandom_range(0, 1) == 1));
  end

  // ---------------- monitor / scoreboard ----------------
  logic        held      = 1'b0;
  logic [25:0] held_word = '0;

  always @(negedge pixel_clk) begin
    logic [25:0] act;
    logic [25:0] exp_w;
    #1;
    act = {bus.pix_data, bus.pix_sof, bus.pix_eol};
    if (pixel_rst || !enable) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(bus.pix_valid), 32'd1);
        check("hold_word", 32'(act), 32'(held_word));
      end
      held      = bus.pix_valid && !bus.pix_ready;
      held_word = act;
    end
    if (bus.pix_valid && bus.pix_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pix_unexpected: got %h expected none at %0t", act, $time);
      end else begin
        exp_w = exp_q.pop_front();
        check("pix", 32'(act), 32'(exp_w));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pixel_clk);
      #2;
    end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      cyc(1);
      i++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_acks(input int target, input int budget);
    int i;
    i = 0;
    while (ack_cnt < target && i < budget) begin
      cyc(1);
      i++;
    end
    check("wait_acks", 32'(ack_cnt >= target), 32'd1);
  endtask

  task automatic stop();
    enable = 1'b0;
    cyc(15);
    check("stop_valid", 32'(bus.pix_valid), 32'd0);
    check("stop_state", 32'(state_dbg), 32'(IDLE));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_req"},  32'(bus.rd_req), 32'd0);
    check({tag, "_rd_addr"}, bus.rd_addr, 32'd0);
    check({tag, "_valid"},   32'(bus.pix_valid), 32'd0);
    check({tag, "_data"},    32'(bus.pix_data), 32'd0);
    check({tag, "_sof"},     32'(bus.pix_sof), 32'd0);
    check({tag, "_eol"},     32'(bus.pix_eol), 32'd0);
    check({tag, "_state"},   32'(state_dbg), 32'(IDLE));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int a0;
    pixel_rst = 1'b1;
    enable    = 1'b0;
    cyc(3);
    check_reset_outputs("rst");
    pixel_rst = 1'b0;
    cyc(2);
    check("idle_rd_req", 32'(bus.rd_req), 32'd0);

    // 1: full frame plus first pixel of the next frame, memory acks every cycle
    base_addr = 32'h1000;
    push_seq(32'h1000, 0, FRAME + 1);
    ready_en = 1'b1;
    enable   = 1'b1;
    drain(600);
    stop();

    // 2: consumer stalled, fetch must stop with exactly D words buffered
    ready_en = 1'b0;
    a0       = ack_cnt;
    enable   = 1'b1;
    cyc(80);
    check("fill_acks", 32'(ack_cnt - a0), 32'(D));
    check("fill_rd_req", 32'(bus.rd_req), 32'd0);
    check("fill_state", 32'(state_dbg), 32'(CHECK));
    check("fill_valid", 32'(bus.pix_valid), 32'd1);
    push_seq(32'h1000, 0, D);
    ready_en = 1'b1;
    drain(300);
    stop();

    // 3: random memory latency and random consumer stalls
    mem_mode   = 1'b1;
    rand_ready = 1'b1;
    push_seq(32'h1000, 0, FRAME + 8);
    enable = 1'b1;
    drain(4000);
    stop();
    mem_mode   = 1'b0;
    rand_ready = 1'b0;

    // 4: enable dropped while a read waits 3 cycles for its ack
    ready_en  = 1'b0;
    mem_delay = 3;
    a0        = ack_cnt;
    enable    = 1'b1;
    wait_acks(a0 + 2, 100);
    check("t4_req_pending", 32'(bus.rd_req), 32'd1);
    enable = 1'b0;
    cyc(15);
    check("t4_ack_done", 32'(ack_cnt - a0), 32'd3);
    check("t4_valid", 32'(bus.pix_valid), 32'd0);
    check("t4_rd_req", 32'(bus.rd_req), 32'd0);
    check("t4_state", 32'(state_dbg), 32'(IDLE));
    base_addr = 32'h2000;
    mem_delay = 0;
    push_seq(32'h2000, 0, 6);
    ready_en = 1'b1;
    enable   = 1'b1;
    drain(300);
    stop();

    // 5: base_addr moves mid-frame; only the next frame uses it
    base_addr = 32'h1000;
    push_seq(32'h1000, 0, FRAME);
    push_seq(32'h8000, 0, 4);
    enable = 1'b1;
    cyc(5);
    base_addr = 32'h8000;
    drain(800);
    stop();

    // 6: reset while a read is outstanding, then a stray ack
    ready_en  = 1'b0;
    mem_delay = 5;
    base_addr = 32'h1000;
    a0        = ack_cnt;
    enable    = 1'b1;
    wait_acks(a0 + 2, 100);
    cyc(1);
    check("t6_req_before_rst", 32'(bus.rd_req), 32'd1);
    pixel_rst = 1'b1;
    enable    = 1'b0;
    cyc(1);
    check_reset_outputs("t6");
    pixel_rst = 1'b0;
    stray_ack = 1'b1;
    cyc(1);
    stray_ack = 1'b0;
    cyc(3);
    check("t6_stray_valid", 32'(bus.pix_valid), 32'd0);
    check("t6_stray_state", 32'(state_dbg), 32'(IDLE));
    check("t6_stray_rd_req", 32'(bus.rd_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
